// File: rtl/mips_memory.sv
// Unified memory for a small MIPS core: word RAM, a memory-mapped output port,
// a free-running cycle counter, and a sticky access-fault recorder.
module mips_memory #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0,
    parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FFF4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    addr,
    input  logic                           memread,
    input  logic                           memwrite,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    memdata,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic [31:0]                    io_out,
    output logic                           io_valid,
    output logic                           fault,
    output logic [31:0]                    fault_addr
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] io_out_q, io_out_d;
    logic        io_valid_q, io_valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic [AW-1:0] word_idx;
    logic          aligned, in_ram, is_io, is_cnt, addr_ok;
    logic          fault_now, ram_we, io_we, cnt_we;
    logic [31:0]   rdata;

    always_comb begin
        word_idx  = addr[AW+1:2];
        aligned   = (addr[1:0] == 2'b00);
        in_ram    = ({1'b0, addr} < RAM_LIMIT);
        is_io     = (addr == IO_ADDR);
        is_cnt    = (addr == CNT_ADDR);
        addr_ok   = aligned && (in_ram || is_io || is_cnt);
        fault_now = ((memread || memwrite) && !addr_ok) || (memread && memwrite);

        // A simultaneous read+write to a good address still faults, but the write lands.
        io_we  = !reset && memwrite && addr_ok && is_io;
        cnt_we = !reset && memwrite && addr_ok && !is_io && is_cnt;
        ram_we = !reset && memwrite && addr_ok && !is_io && !is_cnt && in_ram;

        rdata = '0;
        if (memread) begin
            if (is_io)       rdata = io_out_q;
            else if (is_cnt) rdata = cnt_q;
            else if (in_ram) rdata = mem_q[word_idx];
        end
    end

    always_comb begin
        io_out_d     = io_out_q;
        io_valid_d   = 1'b0;
        cnt_d        = cnt_q + 32'd1;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;

        if (reset) begin
            io_out_d     = '0;
            cnt_d        = '0;
            fault_d      = 1'b0;
            fault_addr_d = '0;
        end else begin
            if (io_we) begin
                io_out_d   = writedata;
                io_valid_d = 1'b1;
            end
            if (cnt_we) cnt_d = writedata;
            if (fault_now) begin
                fault_d = 1'b1;
                if (!fault_q) fault_addr_d = addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        io_out_q     <= io_out_d;
        io_valid_q   <= io_valid_d;
        cnt_q        <= cnt_d;
        fault_q      <= fault_d;
        fault_addr_q <= fault_addr_d;
    end

    // The load port is applied last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (ram_we)  mem_q[word_idx]  <= writedata;
        if (load_en) mem_q[load_addr] <= load_data;
    end

    assign memdata    = rdata;
    assign io_out     = io_out_q;
    assign io_valid   = io_valid_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
endmodule

// File: tb/tb_mips_memory.sv
// Directed bench for mips_memory: expected values queue up as stimulus is driven
// and are popped when the corresponding DUT output is sampled.
module tb_mips_memory;
    localparam logic [31:0] IO_A  = 32'hFFFF_FFF0;
    localparam logic [31:0] CNT_A = 32'hFFFF_FFF4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        memread, memwrite;
    logic [31:0] writedata;
    logic [31:0] memdata;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] io_out;
    logic        io_valid;
    logic        fault;
    logic [31:0] fault_addr;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    mips_memory dut (
        .clk(clk), .reset(reset), .addr(addr), .memread(memread),
        .memwrite(memwrite), .writedata(writedata), .memdata(memdata),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .io_out(io_out), .io_valid(io_valid), .fault(fault),
        .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        memread   = rd;
        memwrite  = wr;
        addr      = a;
        writedata = d;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Program load and ignored processor writes while in reset
        load(8'd0, 32'h2008_0005);
        tick();
        load(8'd4, 32'h1111_1111);
        tick();
        load(8'd5, 32'h5555_5555);
        drive(1'b0, 1'b1, 32'h14, 32'h0000_0BAD);
        tick();
        load_en = 1'b0;
        drive(1'b0, 1'b1, IO_A, 32'h0000_00AA);
        tick();
        drive(1'b1, 1'b0, CNT_A, 32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        chk("rst_io_out", io_out);
        chk("rst_io_valid", 32'(io_valid));
        chk("rst_fault", 32'(fault));
        chk("rst_fault_addr", fault_addr);
        chk("rst_counter", memdata);

        // Release reset; zero-latency read of loaded word
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h2008_0005);
        @(negedge clk);
        chk("read_loaded", memdata);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h0);
        #1 chk("read_no_strobe", memdata);
        drive(1'b1, 1'b0, 32'h14, 32'h0);
        exp_q.push_back(32'h5555_5555);
        #1 chk("reset_write_ignored", memdata);

        // RAM write then read back
        tick();
        drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
        @(negedge clk);
        chk("ram_readback", memdata);
        chk("no_fault_after_write", 32'(fault));

        // Output port: single write, then back-to-back
        tick();
        drive(1'b0, 1'b1, IO_A, 32'h7);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h7); exp_q.push_back(32'h1);
        @(negedge clk);
        chk("io_single_out", io_out);
        chk("io_single_valid", 32'(io_valid));
        tick();
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("io_single_pulse_end", 32'(io_valid));
        tick();
        drive(1'b0, 1'b1, IO_A, 32'h7);
        tick();
        drive(1'b0, 1'b1, IO_A, 32'h9);
        exp_q.push_back(32'h1); exp_q.push_back(32'h7);
        @(negedge clk);
        chk("io_b2b_valid1", 32'(io_valid));
        chk("io_b2b_out1", io_out);
        tick();
        drive(1'b1, 1'b0, IO_A, 32'h0);
        exp_q.push_back(32'h1); exp_q.push_back(32'h9); exp_q.push_back(32'h9);
        @(negedge clk);
        chk("io_b2b_valid2", 32'(io_valid));
        chk("io_b2b_out2", io_out);
        chk("io_readback", memdata);
        tick();
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("io_b2b_pulse_end", 32'(io_valid));

        // Counter load and wrap
        drive(1'b0, 1'b1, CNT_A, 32'hFFFF_FFFE);
        tick();
        drive(1'b1, 1'b0, CNT_A, 32'h0);
        exp_q.push_back(32'hFFFF_FFFE);
        @(negedge clk);
        chk("cnt_loaded", memdata);
        tick();
        exp_q.push_back(32'hFFFF_FFFF);
        @(negedge clk);
        chk("cnt_plus1", memdata);
        tick();
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("cnt_wrap", memdata);
        tick();
        exp_q.push_back(32'h1);
        @(negedge clk);
        chk("cnt_after_wrap", memdata);

        // Load vs processor write: same index, then different indices
        tick();
        load(8'd6, 32'hAAAA_0006);
        drive(1'b0, 1'b1, 32'h18, 32'hBBBB_0006);
        tick();
        load(8'd7, 32'hCCCC_0007);
        drive(1'b0, 1'b1, 32'h20, 32'hDDDD_0008);
        tick();
        load_en = 1'b0;
        drive(1'b1, 1'b0, 32'h18, 32'h0);
        exp_q.push_back(32'hAAAA_0006);
        @(negedge clk);
        chk("load_wins_collision", memdata);
        drive(1'b1, 1'b0, 32'h1C, 32'h0);
        exp_q.push_back(32'hCCCC_0007);
        #1 chk("load_other_index", memdata);
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        exp_q.push_back(32'hDDDD_0008); exp_q.push_back(32'h0);
        #1 chk("proc_other_index", memdata);
        chk("load_no_fault", 32'(fault));

        // Faults: misaligned, then out of range
        tick();
        drive(1'b0, 1'b1, 32'h12, 32'h0000_BAD0);
        tick();
        drive(1'b0, 1'b1, 32'h800, 32'h0000_BAD1);
        exp_q.push_back(32'h1); exp_q.push_back(32'h12);
        @(negedge clk);
        chk("fault_misaligned", 32'(fault));
        chk("fault_addr_first", fault_addr);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h12);
        @(negedge clk);
        chk("misaligned_write_suppressed", memdata);
        chk("fault_addr_sticky", fault_addr);
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h2008_0005);
        #1 chk("oor_write_suppressed", memdata);
        drive(1'b1, 1'b0, 32'h800, 32'h0);
        exp_q.push_back(32'h0);
        #1 chk("oor_read_zero", memdata);

        // Simultaneous read+write at a good address: write proceeds
        tick();
        drive(1'b1, 1'b1, 32'h24, 32'h2424_2424);
        tick();
        drive(1'b1, 1'b0, 32'h24, 32'h0);
        exp_q.push_back(32'h2424_2424); exp_q.push_back(32'h12); exp_q.push_back(32'h1);
        @(negedge clk);
        chk("rw_write_proceeds", memdata);
        chk("rw_fault_addr_kept", fault_addr);
        chk("rw_fault_set", 32'(fault));

        // Mid-operation reset drops pending io_valid and clears fault state
        tick();
        drive(1'b0, 1'b1, IO_A, 32'h33);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h1);
        @(negedge clk);
        chk("pre_reset_io_valid", 32'(io_valid));
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("midrst_io_valid", 32'(io_valid));
        chk("midrst_io_out", io_out);
        chk("midrst_fault", 32'(fault));
        chk("midrst_fault_addr", fault_addr);
        chk("midrst_ram_intact", memdata);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h24, 32'h0);
        exp_q.push_back(32'h2424_2424);
        @(negedge clk);
        chk("post_reset_ram_intact", memdata);

        if (exp_q.size() != 0) begin
            n_errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_memory.md
MIPS_MEMORY -- requirements
Module: mips_memory

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit RAM words (power of two, at least 4).
REQ-002 The block SHALL have parameter IO_ADDR, default 32'hFFFF_FFF0, meaning the byte address of the output port register.
REQ-003 The block SHALL have parameter CNT_ADDR, default 32'hFFFF_FFF4, meaning the byte address of the cycle counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port addr, input, 32 bits: the processor byte address.
REQ-007 The block SHALL have port memread, input, 1 bit: the processor read strobe.
REQ-008 The block SHALL have port memwrite, input, 1 bit: the processor write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits: the processor write data.
REQ-010 The block SHALL have port memdata, output, 32 bits: the read data returned to the processor.
REQ-011 The block SHALL have port load_en, input, 1 bit: the bench/boot program-load strobe.
REQ-012 The block SHALL have port load_addr, input, log2(DEPTH_WORDS) bits: the load word index.
REQ-013 The block SHALL have port load_data, input, 32 bits: the load word.
REQ-014 The block SHALL have port io_out, output, 32 bits: the output port register.
REQ-015 The block SHALL have port io_valid, output, 1 bit: a one-cycle pulse per io_out update.
REQ-016 The block SHALL have port fault, output, 1 bit: the sticky access-error flag.
REQ-017 The block SHALL have port fault_addr, output, 32 bits: the address of the first faulting access.

Function
REQ-018 RAM reads SHALL be combinational with zero latency: when memread=1, memdata = RAM[addr[log2(DEPTH_WORDS)+1:2]], with addr[1:0] ignored.
REQ-019 A RAM write SHALL occur on the clock edge where memwrite=1 and the access is valid, storing writedata; the new value SHALL be readable in the next cycle.
REQ-020 An access SHALL be valid only when addr[1:0]=0 and the address is below 4*DEPTH_WORDS, IO_ADDR, or CNT_ADDR.
REQ-021 A read at IO_ADDR SHALL return io_out; a read at CNT_ADDR SHALL return the current counter value.
REQ-022 A read of an out-of-range address, or any read with memread=0, SHALL return memdata=0.
REQ-023 A write to IO_ADDR SHALL set io_out to writedata on the next edge and SHALL assert io_valid for exactly the following cycle; back-to-back writes SHALL keep io_valid high.
REQ-024 The counter SHALL be 32 bits, SHALL increment by 1 every cycle outside reset, and SHALL wrap from FFFF_FFFF to 0.
REQ-025 A write to CNT_ADDR SHALL load writedata into the counter, which SHALL then increment in the following cycle.
REQ-026 A fault SHALL be any memread or memwrite access that is misaligned or out of range, or memread and memwrite asserted together.
REQ-027 A faulting write SHALL be suppressed, except that with memread=memwrite=1 and a valid address the write SHALL proceed, with write taking priority.
REQ-028 fault SHALL be set on the edge after the first fault and SHALL remain set until reset.
REQ-029 fault_addr SHALL capture addr on the first fault only; later faults SHALL NOT update it.
REQ-030 When load_en=1, RAM[load_addr] SHALL be written with load_data on the edge, in or out of reset.
REQ-031 When load_en=1 and a processor RAM write occur in the same cycle, load SHALL win at a matching index, and both writes SHALL occur otherwise.
REQ-032 Load SHALL never set fault.

Reset
REQ-033 While reset=1 the block SHALL hold io_out=0, io_valid=0, fault=0, fault_addr=0, and counter=0, and SHALL ignore processor writes.
REQ-034 RAM contents SHALL NOT be cleared by reset.
REQ-035 Reset asserted mid-operation SHALL take effect on the next edge and SHALL discard any pending io_valid pulse.

Verification
REQ-036 Load RAM[0]=0x2008_0005 during reset, release reset, addr=0 with memread=1 -> memdata=0x2008_0005 in the same cycle.
REQ-037 memwrite to addr=0x10 with data 0xDEAD_BEEF, then read addr=0x10 next cycle -> 0xDEAD_BEEF, and fault=0.
REQ-038 Write 0x0000_0007 to IO_ADDR -> io_out=7 and io_valid high for one cycle; two consecutive writes (7, 9) -> io_valid high for two cycles and io_out=9.
REQ-039 Write 0xFFFF_FFFE to CNT_ADDR, then read CNT_ADDR after 1, 2, and 3 cycles -> 0xFFFF_FFFF, 0x0, 0x1.
REQ-040 memwrite to addr=0x12 (misaligned), then to addr=0x800 (out of range, default DEPTH) -> RAM unchanged, fault=1, fault_addr=0x12; reset -> fault=0 and fault_addr=0 with RAM intact.
